addsub_share_sched: RTL

//  Shares one 32-bit add/sub datapath (ADD/ADC/SUB/SBC/RSB/CMP/CMN) between NREQ requesters.

---
 rtl/addsub_pkg.sv | 103 ++++++++++
 rtl/addsub_share_sched_rr_arbiter.sv | 40 ++++
 rtl/addsub_share_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: opcodes, flag indices, FSM states and the opcode decoder
// shared by the add/sub scheduler.
package addsub_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDS = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_ADCS = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_SUBS = 4'h5;
  localparam logic [3:0] OP_SBC  = 4'h6;
  localparam logic [3:0] OP_SBCS = 4'h7;
  localparam logic [3:0] OP_RSB  = 4'h8;
  localparam logic [3:0] OP_RSBS = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_CMN  = 4'hB;
  localparam logic [3:0] OP_LADD = 4'hC;
  localparam logic [3:0] OP_LSUB = 4'hD;

  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI
  } state_t;

  typedef struct packed {
    logic swap;
    logic inv_b;
    logic use_c;
    logic cin;
    logic wr;
    logic lng;
    logic err;
  } dec_t;

  // swap feeds (b, a) to the adder so RSB reuses the b-inverting path
  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_ADD:  ;
      OP_ADDS: d.wr = 1'b1;
      OP_ADC:  d.use_c = 1'b1;
      OP_ADCS: begin
        d.use_c = 1'b1;
        d.wr    = 1'b1;
      end
      OP_SUB: begin
        d.inv_b = 1'b1;
        d.cin   = 1'b1;
      end
      OP_SUBS: begin
        d.inv_b = 1'b1;
        d.cin   = 1'b1;
        d.wr    = 1'b1;
      end
      OP_SBC: begin
        d.inv_b = 1'b1;
        d.use_c = 1'b1;
      end
      OP_SBCS: begin
        d.inv_b = 1'b1;
        d.use_c = 1'b1;
        d.wr    = 1'b1;
      end
      OP_RSB: begin
        d.swap  = 1'b1;
        d.inv_b = 1'b1;
        d.cin   = 1'b1;
      end
      OP_RSBS: begin
        d.swap  = 1'b1;
        d.inv_b = 1'b1;
        d.cin   = 1'b1;
        d.wr    = 1'b1;
      end
      OP_CMP: begin
        d.inv_b = 1'b1;
        d.cin   = 1'b1;
        d.wr    = 1'b1;
      end
      OP_CMN:  d.wr = 1'b1;
      OP_LADD: begin
        d.lng = 1'b1;
        d.wr  = 1'b1;
      end
      OP_LSUB: begin
        d.lng   = 1'b1;
        d.inv_b = 1'b1;
        d.cin   = 1'b1;
        d.wr    = 1'b1;
      end
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/addsub_share_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the pointer moves to the
// granted id only when the grant is taken (adv).
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid
);

  logic [IDW-1:0] ptr;

  // scan farthest-first so the nearest requester after ptr wins
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    gid   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (|(req & (NREQ'(1) << j))) begin
        grant = NREQ'(1) << j;
        gid   = IDW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IDW'(NREQ - 1);
    end else if (adv) begin
      ptr <= gid;
    end
  end

endmodule

// File: rtl/addsub_share_sched.sv
// addsub_share_sched: round-robin shared add/sub datapath owning NZCV.
// Define ADDSUB_LONG_EN to enable the two-cycle LADD/LSUB 2*W ops.
module addsub_share_sched
  import addsub_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 32,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*4-1:0]   req_op,
  input  logic [NREQ*2*W-1:0] req_a,
  input  logic [NREQ*2*W-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_s,
  output logic [3:0]          rsp_flags,
  output logic                rsp_err,
  output logic [3:0]          flags_q
);

  localparam int DW = 2 * W;

  state_t          st;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gid;
  logic            can;
  logic            accept;
  logic            ill;
  logic            lng;
  logic [3:0]      op_sel;
  logic [DW-1:0]   a_sel;
  logic [DW-1:0]   b_sel;
  dec_t            dec;
  logic [W-1:0]    x;
  logic [W-1:0]    y;
  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic            add_c;
  logic [W:0]      sum;
  logic            zero;
  logic            ovf;
  logic [3:0]      fl;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .adv   (accept),
    .grant (grant),
    .gid   (gid)
  );

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gid == IDW'(i)) begin
        op_sel = req_op[i*4 +: 4];
        a_sel  = req_a[i*DW +: DW];
        b_sel  = req_b[i*DW +: DW];
      end
    end
  end

  assign dec = decode(op_sel);

`ifdef ADDSUB_LONG_EN
  logic [W-1:0]   hi_a;
  logic [W-1:0]   hi_b;
  logic [W-1:0]   lo_s;
  logic           lo_c;
  logic [IDW-1:0] lid;
  logic [3:0]     lfl;

  assign ill = dec.err;
  assign lng = dec.lng;
`else
  logic unused;

  assign st     = ST_IDLE;
  assign ill    = dec.err | dec.lng;
  assign lng    = 1'b0;
  assign unused = ^{a_sel[DW-1:W], b_sel[DW-1:W]};
`endif

  assign can = rst_n && (st == ST_IDLE) && (!rsp_valid || rsp_ready);
  assign req_ready = can ? grant : '0;
  assign accept = |req_ready;

  // LO reuses the same adder for the captured high half
  always_comb begin
    x     = dec.swap ? b_sel[W-1:0] : a_sel[W-1:0];
    y     = dec.swap ? a_sel[W-1:0] : b_sel[W-1:0];
    add_a = x;
    add_b = dec.inv_b ? ~y : y;
    add_c = dec.use_c ? flags_q[FC] : dec.cin;
`ifdef ADDSUB_LONG_EN
    if (st == ST_LO) begin
      add_a = hi_a;
      add_b = hi_b;
      add_c = lo_c;
    end
`endif
  end

  assign sum  = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c};
  assign zero = (sum[W-1:0] == '0);
  assign ovf  = (add_a[W-1] == add_b[W-1]) && (sum[W-1] != add_a[W-1]);
  assign fl   = {sum[W-1], zero, sum[W], ovf};

`ifdef ADDSUB_LONG_EN
  assign lfl = {sum[W-1], zero && (lo_s == '0), sum[W], ovf};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= ST_IDLE;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (accept && lng) begin
            st   <= ST_LO;
            hi_a <= a_sel[DW-1:W];
            hi_b <= dec.inv_b ? ~b_sel[DW-1:W] : b_sel[DW-1:W];
            lo_s <= sum[W-1:0];
            lo_c <= sum[W];
            lid  <= gid;
          end
        end
        ST_LO:   st <= ST_HI;
        ST_HI:   st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      flags_q   <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (accept && !lng) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gid;
        rsp_err   <= ill;
        rsp_s     <= ill ? '0 : {{W{1'b0}}, sum[W-1:0]};
        rsp_flags <= ill ? 4'b0 : fl;
        if (!ill && dec.wr) begin
          flags_q <= fl;
        end
      end
`ifdef ADDSUB_LONG_EN
      if (st == ST_LO) begin
        rsp_valid <= 1'b1;
        rsp_id    <= lid;
        rsp_err   <= 1'b0;
        rsp_s     <= {sum[W-1:0], lo_s};
        rsp_flags <= lfl;
        flags_q   <= lfl;
      end
`endif
    end
  end

endmodule
